// File: rtl/rom_arb_pkg.sv
// Shared types and default widths for the ROM access arbiter.
package rom_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  typedef enum logic {
    REQ_CPU,
    REQ_VID
  } req_id_e;

endpackage

// File: rtl/rom_access_arbiter_if.sv
// Requester and ROM-side signals of the arbiter, bundled with arbiter/requester views.
interface rom_access_arbiter_if #(
  parameter int unsigned ADDR_W = rom_arb_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = rom_arb_pkg::DATA_W_DEF
);

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic [ADDR_W-1:0] rom_A;
  logic              rom_CS_b;
  logic              rom_OE_b;
  logic [DATA_W-1:0] rom_Dout;

  modport slave (
    input  cpu_req, cpu_addr, vid_req, vid_addr, rom_Dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           rom_A, rom_CS_b, rom_OE_b
  );

  modport master (
    output cpu_req, cpu_addr, vid_req, vid_addr, rom_Dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vid_gnt, vid_rvalid, vid_rdata,
           rom_A, rom_CS_b, rom_OE_b
  );

endinterface

// File: rtl/rom_arb_pick.sv
// Winner selection: video by default, CPU once it has watched STARVE_LIMIT video grants.
module rom_arb_pick
  import rom_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    cpu_req,
  input  logic    vid_req,
  input  logic    grant,
  output req_id_e winner
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved = (starve_q == CW'(STARVE_LIMIT));

  always_comb begin
    winner = (cpu_req && (!vid_req || starved)) ? REQ_CPU : REQ_VID;
  end

  // The count only means anything while the CPU is actually waiting.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_req) begin
      starve_d = '0;
    end else if (grant) begin
      if (winner == REQ_CPU) begin
        starve_d = '0;
      end else if (!starved) begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous ROM between CPU and video; fixed gnt-to-rvalid latency of 3 cycles.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  rom_access_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  req_id_e           cur_q, cur_d;
  req_id_e           cap_id_q, cap_id_d;
  req_id_e           winner;
  logic              cap_q, cap_d;
  logic              cpu_gnt_q, cpu_gnt_d, vid_gnt_q, vid_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, vid_rvalid_q, vid_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;
  logic [ADDR_W-1:0] rom_a_q, rom_a_d;
  logic              rom_en_b_q, rom_en_b_d;
  logic              any_req, grant;

  assign any_req = bus.cpu_req | bus.vid_req;
  assign grant   = any_req && (state_q == IDLE || state_q == DATA);

  rom_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .cpu_req(bus.cpu_req),
    .vid_req(bus.vid_req),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    rom_a_d      = rom_a_q;
    rom_en_b_d   = rom_en_b_q;
    cap_d        = 1'b0;
    cap_id_d     = cap_id_q;
    cpu_gnt_d    = 1'b0;
    vid_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    vid_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    vid_rdata_d  = vid_rdata_q;

    // Capture trails DATA by one cycle: the ROM output for that access is valid now.
    if (cap_q) begin
      if (cap_id_q == REQ_CPU) begin
        cpu_rvalid_d = 1'b1;
        cpu_rdata_d  = bus.rom_Dout;
      end else begin
        vid_rvalid_d = 1'b1;
        vid_rdata_d  = bus.rom_Dout;
      end
    end

    unique case (state_q)
      IDLE: ;
      ADDR: state_d = DATA;
      DATA: begin
        cap_d    = 1'b1;
        cap_id_d = cur_q;
        if (!any_req) begin
          state_d    = IDLE;
          rom_en_b_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d    = ADDR;
      cur_d      = winner;
      rom_en_b_d = 1'b0;
      if (winner == REQ_CPU) begin
        cpu_gnt_d = 1'b1;
        rom_a_d   = bus.cpu_addr;
      end else begin
        vid_gnt_d = 1'b1;
        rom_a_d   = bus.vid_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= REQ_CPU;
      cap_q        <= 1'b0;
      cap_id_q     <= REQ_CPU;
      cpu_gnt_q    <= 1'b0;
      vid_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
      rom_a_q      <= '0;
      rom_en_b_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      cap_q        <= cap_d;
      cap_id_q     <= cap_id_d;
      cpu_gnt_q    <= cpu_gnt_d;
      vid_gnt_q    <= vid_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rvalid_q <= vid_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rdata_q  <= vid_rdata_d;
      rom_a_q      <= rom_a_d;
      rom_en_b_q   <= rom_en_b_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.vid_gnt    = vid_gnt_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.vid_rdata  = vid_rdata_q;
  assign bus.rom_A      = rom_a_q;
  assign bus.rom_CS_b   = rom_en_b_q;
  assign bus.rom_OE_b   = rom_en_b_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: behavioural synchronous ROM plus scripted requesters.
module tb_rom_access_arbiter;
  import rom_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_access_arbiter_if #(.ADDR_W(14), .DATA_W(8)) bus_if ();

  rom_access_arbiter #(
    .ADDR_W      (14),
    .DATA_W      (8),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int total, bad, tcyc, both_gnt;
  bit cpu_hold, vid_hold;
  int cg[$], vg[$], cr[$], vr[$];
  logic [7:0] cd[$], vd[$];

  function automatic logic [7:0] rom_val(input logic [13:0] a);
    if (a == 14'h1234) return 8'hA5;
    return a[7:0] + {2'b00, a[13:8]} + 8'h11;
  endfunction

  // ROM registers its output on the clock edge that samples it enabled.
  always @(posedge clk)
    if (!bus_if.rom_CS_b && !bus_if.rom_OE_b) bus_if.rom_Dout <= rom_val(bus_if.rom_A);

  function automatic string q2s(input int q[$]);
    string s = "";
    foreach (q[i]) s = {s, (i == 0) ? "" : ",", $sformatf("%0d", q[i])};
    return s;
  endfunction

  function automatic string d2s(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, (i == 0) ? "" : ",", $sformatf("%02h", q[i])};
    return s;
  endfunction

  task automatic clear_log();
    cg.delete(); vg.delete(); cr.delete(); vr.delete(); cd.delete(); vd.delete();
    tcyc = 0;
    both_gnt = 0;
  endtask

  // One cycle: sample at negedge, log events, requesters drop req once granted.
  task automatic step();
    @(negedge clk);
    tcyc++;
    if (bus_if.cpu_gnt && bus_if.vid_gnt) both_gnt++;
    if (bus_if.cpu_gnt) begin
      cg.push_back(tcyc);
      if (!cpu_hold) bus_if.cpu_req = 1'b0;
    end
    if (bus_if.vid_gnt) begin
      vg.push_back(tcyc);
      if (!vid_hold) bus_if.vid_req = 1'b0;
    end
    if (bus_if.cpu_rvalid) begin cr.push_back(tcyc); cd.push_back(bus_if.cpu_rdata); end
    if (bus_if.vid_rvalid) begin vr.push_back(tcyc); vd.push_back(bus_if.vid_rdata); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.cpu_req = 1'b0; bus_if.vid_req = 1'b0;
    bus_if.cpu_addr = '0; bus_if.vid_addr = '0;
    bus_if.rom_Dout = '0;
    cpu_hold = 1'b0; vid_hold = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus_if.rom_CS_b, bus_if.rom_OE_b} !== 2'b11) begin
      bad++; $display("FAIL reset_enables: got %b exp 11", {bus_if.rom_CS_b, bus_if.rom_OE_b});
    end
    total++;
    if (bus_if.rom_A !== 14'h0) begin
      bad++; $display("FAIL reset_rom_A: got %h exp 0000", bus_if.rom_A);
    end
    total++;
    if ({bus_if.cpu_gnt, bus_if.vid_gnt} !== 2'b00) begin
      bad++; $display("FAIL reset_gnt: got %b exp 00", {bus_if.cpu_gnt, bus_if.vid_gnt});
    end
    total++;
    if ({bus_if.cpu_rvalid, bus_if.vid_rvalid} !== 2'b00) begin
      bad++; $display("FAIL reset_rvalid: got %b exp 00", {bus_if.cpu_rvalid, bus_if.vid_rvalid});
    end
    total++;
    if ({bus_if.cpu_rdata, bus_if.vid_rdata} !== 16'h0) begin
      bad++; $display("FAIL reset_rdata: got %h exp 0000", {bus_if.cpu_rdata, bus_if.vid_rdata});
    end
    rst = 1'b0;
    clear_log();
    repeat (2) step();
    total++;
    if (cg.size() + vg.size() != 0 || bus_if.rom_CS_b !== 1'b1) begin
      bad++; $display("FAIL idle_quiet: got gnts=%0d cs_b=%b exp 0/1", cg.size() + vg.size(),
                      bus_if.rom_CS_b);
    end
  endtask

  task automatic test_cpu_read();
    clear_log();
    bus_if.cpu_addr = 14'h1234;
    bus_if.cpu_req = 1'b1;
    step();
    total++;
    if (bus_if.cpu_gnt !== 1'b1 || bus_if.vid_gnt !== 1'b0) begin
      bad++; $display("FAIL cpu_gnt_T: got cpu=%b vid=%b exp 1/0", bus_if.cpu_gnt, bus_if.vid_gnt);
    end
    total++;
    if (bus_if.rom_A !== 14'h1234 || {bus_if.rom_CS_b, bus_if.rom_OE_b} !== 2'b00) begin
      bad++; $display("FAIL cpu_rom_T: got A=%h en=%b exp 1234/00", bus_if.rom_A,
                      {bus_if.rom_CS_b, bus_if.rom_OE_b});
    end
    step();
    total++;
    if (bus_if.rom_A !== 14'h1234 || {bus_if.rom_CS_b, bus_if.rom_OE_b} !== 2'b00) begin
      bad++; $display("FAIL cpu_rom_T1: got A=%h en=%b exp 1234/00", bus_if.rom_A,
                      {bus_if.rom_CS_b, bus_if.rom_OE_b});
    end
    step();
    total++;
    if ({bus_if.rom_CS_b, bus_if.rom_OE_b} !== 2'b11 || bus_if.cpu_rvalid !== 1'b0) begin
      bad++; $display("FAIL cpu_T2: got en=%b rvalid=%b exp 11/0",
                      {bus_if.rom_CS_b, bus_if.rom_OE_b}, bus_if.cpu_rvalid);
    end
    step();
    total++;
    if (bus_if.cpu_rvalid !== 1'b1 || bus_if.cpu_rdata !== 8'hA5) begin
      bad++; $display("FAIL cpu_rvalid_T3: got rvalid=%b data=%h exp 1/a5", bus_if.cpu_rvalid,
                      bus_if.cpu_rdata);
    end
    step();
    total++;
    if (bus_if.cpu_rvalid !== 1'b0 || bus_if.cpu_rdata !== 8'hA5 || bus_if.rom_A !== 14'h1234)
    begin
      bad++; $display("FAIL cpu_hold_T4: got rvalid=%b data=%h A=%h exp 0/a5/1234",
                      bus_if.cpu_rvalid, bus_if.cpu_rdata, bus_if.rom_A);
    end
    total++;
    if (q2s(cg) != "1" || vg.size() != 0) begin
      bad++; $display("FAIL cpu_gnt_count: got cpu=[%s] vid=%0d exp [1] 0", q2s(cg), vg.size());
    end
  endtask

  task automatic test_simultaneous();
    clear_log();
    bus_if.cpu_addr = 14'h0001; bus_if.vid_addr = 14'h0002;
    bus_if.cpu_req = 1'b1; bus_if.vid_req = 1'b1;
    repeat (7) begin
      step();
      if (tcyc == 4) begin
        total++;
        if (bus_if.cpu_rdata !== 8'hA5 || bus_if.cpu_rvalid !== 1'b0) begin
          bad++; $display("FAIL sim_cpu_untouched: got data=%h rvalid=%b exp a5/0",
                          bus_if.cpu_rdata, bus_if.cpu_rvalid);
        end
      end
    end
    total++;
    if (q2s(vg) != "1") begin bad++; $display("FAIL sim_vid_gnt: got [%s] exp [1]", q2s(vg)); end
    total++;
    if (q2s(cg) != "3") begin bad++; $display("FAIL sim_cpu_gnt: got [%s] exp [3]", q2s(cg)); end
    total++;
    if (q2s(vr) != "4" || d2s(vd) != "13") begin
      bad++; $display("FAIL sim_vid_rvalid: got [%s]/[%s] exp [4]/[13]", q2s(vr), d2s(vd));
    end
    total++;
    if (q2s(cr) != "6" || d2s(cd) != "12") begin
      bad++; $display("FAIL sim_cpu_rvalid: got [%s]/[%s] exp [6]/[12]", q2s(cr), d2s(cd));
    end
    total++;
    if (bus_if.vid_rdata !== 8'h13) begin
      bad++; $display("FAIL sim_vid_rdata_held: got %h exp 13", bus_if.vid_rdata);
    end
  endtask

  task automatic test_back_to_back();
    string cs_s = "";
    clear_log();
    vid_hold = 1'b1;
    bus_if.vid_addr = 14'h3FFE;
    bus_if.vid_req = 1'b1;
    step();
    cs_s = {cs_s, bus_if.rom_CS_b ? "1" : "0"};
    total++;
    if (bus_if.rom_A !== 14'h3FFE) begin
      bad++; $display("FAIL b2b_addr0: got %h exp 3ffe", bus_if.rom_A);
    end
    bus_if.vid_addr = 14'h3FFF;
    vid_hold = 1'b0;
    repeat (6) begin
      step();
      cs_s = {cs_s, bus_if.rom_CS_b ? "1" : "0"};
      if (tcyc == 3) begin
        total++;
        if (bus_if.rom_A !== 14'h3FFF) begin
          bad++; $display("FAIL b2b_addr1: got %h exp 3fff", bus_if.rom_A);
        end
      end
    end
    total++;
    if (cs_s != "0000111") begin bad++; $display("FAIL b2b_cs_b: got %s exp 0000111", cs_s); end
    total++;
    if (q2s(vg) != "1,3") begin bad++; $display("FAIL b2b_gnt: got [%s] exp [1,3]", q2s(vg)); end
    total++;
    if (q2s(vr) != "4,6" || d2s(vd) != "4e,4f") begin
      bad++; $display("FAIL b2b_rvalid: got [%s]/[%s] exp [4,6]/[4e,4f]", q2s(vr), d2s(vd));
    end
  endtask

  task automatic test_starve_pattern();
    clear_log();
    cpu_hold = 1'b1; vid_hold = 1'b1;
    bus_if.cpu_addr = 14'h0155; bus_if.vid_addr = 14'h02AA;
    bus_if.cpu_req = 1'b1; bus_if.vid_req = 1'b1;
    repeat (19) step();
    bus_if.cpu_req = 1'b0; bus_if.vid_req = 1'b0;
    cpu_hold = 1'b0; vid_hold = 1'b0;
    repeat (5) step();
    total++;
    if (q2s(vg) != "1,3,5,7,11,13,15,17") begin
      bad++; $display("FAIL starve_vid_gnt: got [%s] exp [1,3,5,7,11,13,15,17]", q2s(vg));
    end
    total++;
    if (q2s(cg) != "9,19") begin
      bad++; $display("FAIL starve_cpu_gnt: got [%s] exp [9,19]", q2s(cg));
    end
    total++;
    if (both_gnt != 0) begin bad++; $display("FAIL starve_dual_gnt: got %0d exp 0", both_gnt); end
    total++;
    if (q2s(vr) != "4,6,8,10,14,16,18,20" || d2s(vd) != "bd,bd,bd,bd,bd,bd,bd,bd") begin
      bad++; $display("FAIL starve_vid_rvalid: got [%s]/[%s] exp [4,6,8,10,14,16,18,20]/bd x8",
                      q2s(vr), d2s(vd));
    end
    total++;
    if (q2s(cr) != "12,22" || d2s(cd) != "67,67") begin
      bad++; $display("FAIL starve_cpu_rvalid: got [%s]/[%s] exp [12,22]/[67,67]", q2s(cr),
                      d2s(cd));
    end
  endtask

  task automatic test_cpu_drop();
    clear_log();
    cpu_hold = 1'b1; vid_hold = 1'b1;
    bus_if.cpu_addr = 14'h0155; bus_if.vid_addr = 14'h02AA;
    bus_if.cpu_req = 1'b1; bus_if.vid_req = 1'b1;
    repeat (3) step();
    bus_if.cpu_req = 1'b0;
    step();
    bus_if.cpu_req = 1'b1;
    repeat (9) step();
    bus_if.cpu_req = 1'b0; bus_if.vid_req = 1'b0;
    cpu_hold = 1'b0; vid_hold = 1'b0;
    repeat (4) step();
    total++;
    if (q2s(vg) != "1,3,5,7,9,11") begin
      bad++; $display("FAIL drop_vid_gnt: got [%s] exp [1,3,5,7,9,11]", q2s(vg));
    end
    total++;
    if (q2s(cg) != "13") begin bad++; $display("FAIL drop_cpu_gnt: got [%s] exp [13]", q2s(cg)); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    bus_if.cpu_addr = 14'h1234;
    bus_if.cpu_req = 1'b1;
    step();
    total++;
    if (bus_if.cpu_gnt !== 1'b1) begin
      bad++; $display("FAIL rmid_gnt: got %b exp 1", bus_if.cpu_gnt);
    end
    rst = 1'b1;
    bus_if.cpu_req = 1'b0;
    #1;
    total++;
    if ({bus_if.rom_CS_b, bus_if.rom_OE_b} !== 2'b11 || bus_if.rom_A !== 14'h0) begin
      bad++; $display("FAIL rmid_rom: got en=%b A=%h exp 11/0000",
                      {bus_if.rom_CS_b, bus_if.rom_OE_b}, bus_if.rom_A);
    end
    total++;
    if (bus_if.cpu_gnt !== 1'b0 || bus_if.cpu_rdata !== 8'h00 || bus_if.vid_rdata !== 8'h00) begin
      bad++; $display("FAIL rmid_outputs: got gnt=%b cdata=%h vdata=%h exp 0/00/00",
                      bus_if.cpu_gnt, bus_if.cpu_rdata, bus_if.vid_rdata);
    end
    repeat (2) step();
    rst = 1'b0;
    bus_if.vid_addr = 14'h0002;
    bus_if.vid_req = 1'b1;
    step();
    total++;
    if (bus_if.vid_gnt !== 1'b1) begin
      bad++; $display("FAIL rmid_first_gnt: got %b exp 1", bus_if.vid_gnt);
    end
    repeat (6) step();
    total++;
    if (cr.size() != 0 || bus_if.cpu_rdata !== 8'h00) begin
      bad++; $display("FAIL rmid_no_cpu_rvalid: got [%s] data=%h exp [] 00", q2s(cr),
                      bus_if.cpu_rdata);
    end
    total++;
    if (q2s(vr) != "7" || d2s(vd) != "13") begin
      bad++; $display("FAIL rmid_vid_rvalid: got [%s]/[%s] exp [7]/[13]", q2s(vr), d2s(vd));
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_back_to_back();
    test_starve_pattern();
    test_cpu_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_access_arbiter.md
ROM_ACCESS_ARBITER -- requirements
Module: rom_access_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 14, ROM address width (16K x 8 part).
REQ-002 SHALL have parameter: DATA_W, 8, ROM data width.
REQ-003 SHALL have parameter: STARVE_LIMIT, 4, max consecutive video grants while CPU waits.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  single system clock, all state on posedge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 cpu_req  input  1  CPU read request, level, held until cpu_gnt.
REQ-008 cpu_addr  input  ADDR_W  CPU read address, stable while cpu_req high.
REQ-009 cpu_gnt  output  1  one-cycle pulse: CPU request accepted.
REQ-010 cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
REQ-011 cpu_rdata  output  DATA_W  CPU read data, held until next CPU capture.
REQ-012 vid_req, vid_addr, vid_gnt, vid_rvalid, vid_rdata: same directions, widths, meaning as CPU port, for video fetch.
REQ-013 rom_A  output  ADDR_W  ROM address.
REQ-014 rom_CS_b, rom_OE_b  output  1 each  ROM chip/output enables, active-low.
REQ-015 rom_Dout  input  DATA_W  ROM data; ROM registers it one clk edge after A/CS_b/OE_b sampled.

Function
REQ-016 FSM states SHALL be IDLE, ADDR, DATA; all outputs registered.
REQ-017 IDLE: if any req, pick winner, pulse its gnt, latch its addr into rom_A, assert rom_CS_b=0/rom_OE_b=0, go ADDR.
REQ-018 ADDR: hold rom_A/enables one cycle (ROM samples at end of this cycle), go DATA.
REQ-019 DATA: capture rom_Dout into winner's rdata, pulse winner's rvalid next cycle; deassert enables unless a new grant issues this cycle.
REQ-020 DATA with pending req SHALL grant directly (gnt pulse, new rom_A, enables stay low), go ADDR; sustained throughput one access per 2 cycles.
REQ-021 Latency SHALL be fixed: gnt in cycle T, rvalid in cycle T+3 with correct data.
REQ-022 Priority: video wins simultaneous requests, except when starve counter = STARVE_LIMIT, then CPU wins.
REQ-023 Starve counter SHALL increment on each video grant while cpu_req high, clear on CPU grant or cpu_req low, saturate at STARVE_LIMIT.
REQ-024 gnt SHALL never pulse to both ports in one cycle; at most one access in flight.
REQ-025 Requester dropping req before gnt SHALL receive no gnt/rvalid; not an error.
REQ-026 rvalid/rdata of the non-winning port SHALL be unchanged during another port's access.
REQ-027 rom_A SHALL pass full address range 0x0000-0x3FFF unmodified; no wrap or offset.
REQ-028 While idle with no request: rom_CS_b=1, rom_OE_b=1, rom_A holds last value.

Reset
REQ-029 On rst: state IDLE, rom_CS_b=1, rom_OE_b=1, rom_A=0, both gnt=0, both rvalid=0, both rdata=0, starve counter=0.
REQ-030 rst asserted mid-access SHALL abandon it; no rvalid for it after release.
REQ-031 First grant possible in first cycle after rst deasserts with req high.

Structure
REQ-032 Package rom_arb_pkg SHALL hold FSM state enum, requester-id enum (REQ_CPU, REQ_VID), ADDR_W/DATA_W defaults.
REQ-033 Winner selection plus starve counter SHALL be one sub-module, rom_arb_pick; FSM and datapath stay in top.

Verification
REQ-034 CPU-only read: ROM[0x1234]=0xA5, cpu_req at T -> cpu_gnt T, rom_A=0x1234 CS/OE low T..T+1, cpu_rvalid T+3, cpu_rdata=0xA5.
REQ-035 Simultaneous req, CPU 0x0001/video 0x0002 -> vid_gnt first, cpu_gnt 2 cycles later, vid_rvalid then cpu_rvalid with correct data.
REQ-036 Both req held continuously -> grants V,V,V,V,C,V,...; CPU never waits more than 4 video grants.
REQ-037 Back-to-back video 0x3FFE, 0x3FFF -> gnts 2 cycles apart, enables never deassert between, data in order, no wrap.
REQ-038 rst pulsed during ADDR of CPU access -> all outputs to reset values immediately, no cpu_rvalid afterwards.
REQ-039 cpu_req dropped for one cycle while video busy -> no cpu_gnt, starve counter returns to 0.
